// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle IF/ID/EXE/MEM/WB control unit with memory wait states, traps, halt and counters
module multicycle_ctrl_fsm #(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src_a,
    output logic               alu_src_b,
    output logic               ext_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               halted,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   instr_count,
    output logic [CNT_W-1:0]   cycle_count
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_TRAP = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110101);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'b101);

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [1:0]          r_trap_cause;
    logic [1:0]          w_trap_next;
    logic [CNT_W-1:0]    r_instr_count;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                w_is_r;
    logic                w_is_branch;
    logic                w_is_mem;
    logic                w_legal;
    logic                w_taken;
    logic                w_timeout;
    logic                w_alu_phase;
    logic                w_waiting;
    logic [ALUOP_W-1:0]  w_dec_alu;

    assign w_is_r      = opcode == OP_ADD || opcode == OP_SUB || opcode == OP_OR ||
                         opcode == OP_AND || opcode == OP_SLT || opcode == OP_SLL;
    assign w_is_branch = opcode == OP_BEQ || opcode == OP_BNE;
    assign w_is_mem    = opcode == OP_LW || opcode == OP_SW;
    assign w_legal     = w_is_r || w_is_branch || w_is_mem || opcode == OP_ADDI ||
                         opcode == OP_ORI || opcode == OP_J || opcode == OP_JR ||
                         opcode == OP_JAL || opcode == OP_HALT;
    assign w_taken     = (opcode == OP_BEQ) ? zero : !zero;
    assign w_waiting   = (r_state == S_IF || r_state == S_MEM) && !mem_ready;
    assign w_timeout   = MEM_TIMEOUT != 0 && !mem_ready && r_wait == WAIT_W'(MEM_TIMEOUT - 1);

    // ALU controls stay decoded from EXE through WB so the result is held for writeback
    assign w_alu_phase = r_state == S_EXE || r_state == S_MEM || r_state == S_WB;
    assign w_dec_alu   = (opcode == OP_SUB || w_is_branch)   ? ALU_SUB :
                         (opcode == OP_OR || opcode == OP_ORI) ? ALU_OR  :
                         (opcode == OP_AND)                  ? ALU_AND :
                         (opcode == OP_SLT)                  ? ALU_SLT :
                         (opcode == OP_SLL)                  ? ALU_SLL : ALU_ADD;
    assign alu_op      = w_alu_phase ? w_dec_alu : '0;
    assign alu_src_a   = w_alu_phase && opcode == OP_SLL;
    assign alu_src_b   = w_alu_phase && (opcode == OP_ADDI || opcode == OP_ORI || w_is_mem);
    assign ext_sel     = w_alu_phase && (opcode == OP_ADDI || w_is_mem || w_is_branch);

    assign state       = r_state;
    assign halted      = r_state == S_HALT;
    assign trap_cause  = r_trap_cause;
    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;

    always_comb begin
        w_next      = r_state;
        w_trap_next = r_trap_cause;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        reg_we      = 1'b0;
        reg_dst     = 2'b00;
        wb_sel      = 2'b00;
        case (r_state)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_ID;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_trap_next = 2'b10;
                end
            end
            S_ID: begin
                if (opcode == OP_J || opcode == OP_JR || opcode == OP_JAL) begin
                    pc_we  = 1'b1;
                    pc_src = (opcode == OP_JR) ? 2'b11 : 2'b10;
                    w_next = S_IF;
                    if (opcode == OP_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'b10;
                        wb_sel  = 2'b10;
                    end
                end else if (opcode == OP_HALT) begin
                    w_next = S_HALT;
                end else if (!w_legal) begin
                    w_next      = S_TRAP;
                    w_trap_next = 2'b01;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                if (w_is_branch) begin
                    pc_we  = 1'b1;
                    pc_src = w_taken ? 2'b01 : 2'b00;
                    w_next = S_IF;
                end else begin
                    w_next = w_is_mem ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = opcode == OP_SW;
                if (mem_ready) begin
                    pc_we  = opcode == OP_SW;
                    w_next = (opcode == OP_SW) ? S_IF : S_WB;
                end else if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_trap_next = 2'b10;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                reg_dst = w_is_r ? 2'b01 : 2'b00;
                wb_sel  = (opcode == OP_LW) ? 2'b01 : 2'b00;
                w_next  = S_IF;
            end
            S_HALT, S_TRAP: w_next = r_state;
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IF;
            r_wait        <= '0;
            r_trap_cause  <= 2'b00;
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_next;
            r_wait        <= w_waiting ? r_wait + 1'b1 : '0;
            r_trap_cause  <= w_trap_next;
            r_instr_count <= r_instr_count + CNT_W'(pc_we);
            r_cycle_count <= r_cycle_count + CNT_W'(r_state != S_HALT && r_state != S_TRAP);
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized instruction-level checking of multicycle_ctrl_fsm against a per-opcode phase model
module tb_multicycle_ctrl_fsm;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR_ = 6'b010000,
                           AND_ = 6'b010001, ORI = 6'b010010, SLT = 6'b100110, SLL = 6'b011000,
                           SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101,
                           J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_a, alu_src_b, ext_sel, halted;
    logic [1:0]  pc_src, reg_dst, wb_sel, trap_cause;
    logic [2:0]  alu_op, state;
    logic [31:0] instr_count, cycle_count;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_instr = 0;
    logic [31:0] exp_cycle = 0;
    logic [1:0]  exp_trap = 0;
    logic [5:0]  ops [15] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLT, SLL, SW, LW, BEQ, BNE, J, JR, JAL};

    multicycle_ctrl_fsm #(.OP_W(6), .ALUOP_W(3), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_op(alu_op), .state(state),
        .halted(halted), .trap_cause(trap_cause), .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {alu_src_a, alu_src_b, ext_sel, alu_op} required in EXE/WB
    function automatic logic [5:0] alu_of(input logic [5:0] op);
        case (op)
            SUB:           return 6'b000_001;
            ADDI, SW, LW:  return 6'b011_000;
            OR_:           return 6'b000_010;
            AND_:          return 6'b000_011;
            ORI:           return 6'b010_010;
            SLT:           return 6'b000_100;
            SLL:           return 6'b100_101;
            BEQ, BNE:      return 6'b001_001;
            default:       return 6'b000_000;
        endcase
    endfunction

    function automatic logic is_rtype(input logic [5:0] op);
        return op == ADD || op == SUB || op == OR_ || op == AND_ || op == SLT || op == SLL;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return op == HALT;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // en = {mem_req, mem_we, ir_we, pc_we, reg_we}; mux = {pc_src, reg_dst, wb_sel}
    task automatic step(input logic rdy, input logic [2:0] st, input logic [4:0] en, input logic [5:0] mux,
                        input logic ca = 1'b0, input logic [5:0] alu = 6'b0, input logic ce = 1'b0);
        mem_ready = rdy;
        #1;
        chk("state", 32'(state), 32'(st));
        chk("enables", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'(en));
        chk("muxes", 32'({pc_src, reg_dst, wb_sel}), 32'(mux));
        chk("halted", 32'(halted), 32'(st == 3'd5));
        chk("trap_cause", 32'(trap_cause), 32'(exp_trap));
        chk("instr_count", instr_count, exp_instr);
        chk("cycle_count", cycle_count, exp_cycle);
        if (ca) begin
            chk("alu_op", 32'(alu_op), 32'(alu[2:0]));
            chk("alu_src_a", 32'(alu_src_a), 32'(alu[5]));
            chk("alu_src_b", 32'(alu_src_b), 32'(alu[4]));
            if (ce) chk("ext_sel", 32'(ext_sel), 32'(alu[3]));
        end
        if (en[1]) exp_instr++;
        if (st != 3'd5 && st != 3'd6) exp_cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_instr = 0;
        exp_cycle = 0;
        exp_trap = 0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enables", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'b10000);
        chk("rst_counts", instr_count | cycle_count | 32'(trap_cause), 32'd0);
        reset = 1'b0;
    endtask

    task automatic absorb(input int n, input logic [2:0] st);
        for (int i = 0; i < n; i++) step(rnd(), st, 5'b0, 6'b0);
        reset_dut();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int ifw, input int memw);
        logic [5:0] a;
        logic       ce;
        logic       sw;
        opcode = op;
        zero   = z;
        a      = alu_of(op);
        ce     = op == ADDI || op == ORI || op == SW || op == LW || op == BEQ || op == BNE;
        sw     = op == SW;
        for (int i = 0; i < ifw && i < 4; i++) step(1'b0, 3'd0, 5'b10000, 6'b0);
        if (ifw >= 4) begin
            exp_trap = 2'b10;
            absorb(6, 3'd6);
            return;
        end
        step(1'b1, 3'd0, 5'b10100, 6'b0);
        if (op == J || op == JR || op == JAL) begin
            step(rnd(), 3'd1, (op == JAL) ? 5'b00011 : 5'b00010,
                 (op == JAL) ? 6'b101010 : (op == JR) ? 6'b110000 : 6'b100000);
            return;
        end
        step(rnd(), 3'd1, 5'b0, 6'b0);
        if (op == HALT) begin
            absorb(5, 3'd5);
            return;
        end
        if (!is_legal(op)) begin
            exp_trap = 2'b01;
            absorb(10, 3'd6);
            return;
        end
        if (op == BEQ || op == BNE) begin
            step(rnd(), 3'd2, 5'b00010, {((op == BEQ) ? z : !z) ? 2'b01 : 2'b00, 4'b0}, 1'b1, a, ce);
            return;
        end
        step(rnd(), 3'd2, 5'b0, 6'b0, 1'b1, a, ce);
        if (op == SW || op == LW) begin
            for (int i = 0; i < memw && i < 4; i++) step(1'b0, 3'd3, {1'b1, sw, 3'b0}, 6'b0);
            if (memw >= 4) begin
                exp_trap = 2'b10;
                absorb(6, 3'd6);
                return;
            end
            if (sw) begin
                step(1'b1, 3'd3, 5'b11010, 6'b0);
                return;
            end
            step(1'b1, 3'd3, 5'b10000, 6'b0);
        end
        step(rnd(), 3'd4, 5'b00011, {2'b00, is_rtype(op) ? 2'b01 : 2'b00, (op == LW) ? 2'b01 : 2'b00}, 1'b1, a, ce);
    endtask

    initial begin
        logic [5:0] op;
        int r;
        reset_dut();
        run_instr(ADD, 1'b0, 0, 0);
        chk("t1_instr", instr_count, 32'd1);
        chk("t1_cycle", cycle_count, 32'd4);
        run_instr(LW, 1'b0, 0, 3);
        run_instr(BEQ, 1'b1, 0, 0);
        run_instr(BNE, 1'b1, 0, 0);
        run_instr(JAL, 1'b0, 1, 0);
        run_instr(6'b000111, 1'b0, 0, 0);
        run_instr(ADD, 1'b0, 4, 0);
        run_instr(ADD, 1'b0, 3, 0);
        run_instr(SW, 1'b0, 2, 4);
        run_instr(SW, 1'b0, 0, 3);
        run_instr(HALT, 1'b0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) op = HALT;
            else if (r < 6) begin
                do op = 6'($urandom); while (is_legal(op));
            end else op = ops[$urandom_range(0, 14)];
            run_instr(op, rnd(), ($urandom_range(0, 59) == 0) ? 4 : $urandom_range(0, 3),
                      ($urandom_range(0, 29) == 0) ? 4 : $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
